// File: rtl/io_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_rx_fifo
// Description : Receive-side byte buffer behind the UART mirror stage.
//               Each rising edge of recv_data_update captures one byte from
//               recv_data into a FIFO. Because the update level may stay high
//               for several cycles, only its rising edge counts. The consumer
//               reads through a show-ahead pop interface. The block reports
//               the fill level, a full flag and a sticky overflow flag.
// Build option: IO_RX_FIFO_CR_TO_LF_EN -- when defined, a pushed 0x0D is
//               stored as 0x0A. When it is undefined, bytes are stored as
//               received.
// Ports       :
//   clk              in   system clock; all state changes on the rising edge
//   rst_n            in   asynchronous active-low reset
//   recv_data        in   [7:0]  byte from the mirror stage
//   recv_data_update in   level; each rising edge marks one new byte
//   pop              in   consumer removes the head byte this cycle
//   clear_overflow   in   synchronous clear of the sticky overflow flag
//   rd_data          out  [7:0]  head byte, valid while rd_valid=1
//   rd_valid         out  FIFO not empty
//   count            out  [AW:0] number of stored bytes, 0..DEPTH
//   full             out  count == DEPTH
//   overflow         out  sticky: a byte was dropped while the FIFO was full
// Revision    : 1.0 - initial release
// ============================================================================
module io_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    recv_data,
    input  logic          recv_data_update,
    input  logic          pop,
    input  logic          clear_overflow,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overflow
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];

    logic          upd_q,      upd_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          overflow_q, overflow_d;

    logic          w_push;
    logic          w_eff_pop;
    logic          w_acc_push;
    logic          w_drop;
    logic [7:0]    w_wr_byte;

    // Byte conversion applied on the way into storage.
`ifdef IO_RX_FIFO_CR_TO_LF_EN
    assign w_wr_byte = (recv_data == 8'h0D) ? 8'h0A : recv_data;
`else
    assign w_wr_byte = recv_data;
`endif

    always_comb begin
        // upd_q resets high, so a level that is already high when reset is
        // released does not count as a rising edge.
        w_push     = recv_data_update & ~upd_q;
        w_eff_pop  = pop & (count_q != '0);
        // A push into a full FIFO is accepted only when a pop frees a slot
        // in the same cycle.
        w_acc_push = w_push & ((count_q != C_DEPTH) | w_eff_pop);
        w_drop     = w_push & ~w_acc_push;

        upd_d      = recv_data_update;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (w_acc_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_eff_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (w_acc_push && !w_eff_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (w_eff_pop && !w_acc_push) begin
            count_d = count_q - (AW+1)'(1);
        end

        // Setting the flag takes priority over a clear in the same cycle.
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            upd_q      <= upd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // The storage array has no reset. Its contents are meaningless whenever
    // count says the slot is not occupied.
    always_ff @(posedge clk) begin
        if (w_acc_push) begin
            mem[wr_ptr_q] <= w_wr_byte;
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;
    assign full     = (count_q == C_DEPTH);
    assign overflow = overflow_q;

endmodule
`default_nettype wire
